// File: rtl/axis_register.sv
// Two-entry AXI-Stream register slice (skid buffer): an output register feeds the
// master side, and a skid register catches the one beat accepted while the output stalls.
module axis_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;
    logic                  skid_valid;
    logic                  in_fire;
    logic                  out_free;

    // Ready depends only on skid occupancy, so m_axis_tready never reaches s_axis_tready.
    assign s_axis_tready = ~skid_valid;
    assign in_fire       = s_axis_tvalid & ~skid_valid;
    assign out_free      = ~m_axis_tvalid | m_axis_tready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out      <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                data_out      <= skid_data;
                m_axis_tlast  <= skid_last;
                m_axis_tvalid <= 1'b1;
            end else if (in_fire) begin
                data_out      <= data_in;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // The skid only fills while the output is full and stalled; it empties as soon as the output frees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            skid_valid <= 1'b0;
        end else if (in_fire) begin
            skid_data  <= data_in;
            skid_last  <= s_axis_tlast;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_register.sv
// Self-checking bench for axis_register: directed scenarios plus a randomized
// backpressure run, all checked against a queue model of the beats held in the slice.
module tb_axis_register;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tready;
    logic [7:0] data_out;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tready;

    int checks = 0;
    int errors = 0;

    // Model: the beats currently held, oldest first, as {last, data}.
    logic [8:0] q[$];
    int         out_count = 0;
    int         in_count  = 0;

    axis_register #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .data_out      (data_out),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the held-beat model at the negedge, then advance through one rising edge.
    task automatic cycle(output bit accepted);
        bit in_fire;
        bit out_fire;
        @(negedge clk);
        check("valid_vs_model", {31'd0, m_axis_tvalid}, {31'd0, q.size() > 0});
        check("ready_vs_model", {31'd0, s_axis_tready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            check("data_vs_model", {24'd0, data_out}, {24'd0, q[0][7:0]});
            check("last_vs_model", {31'd0, m_axis_tlast}, {31'd0, q[0][8]});
        end
        in_fire  = reset && s_axis_tvalid && (q.size() < 2);
        out_fire = reset && m_axis_tready && (q.size() > 0);
        @(posedge clk);
        if (out_fire) begin
            void'(q.pop_front());
            out_count++;
        end
        if (in_fire) begin
            q.push_back({s_axis_tlast, data_in});
            in_count++;
        end
        accepted = in_fire;
        #1;
    endtask

    task automatic step();
        bit acc;
        cycle(acc);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_axis_tvalid = v;
        data_in       = d;
        s_axis_tlast  = l;
    endtask

    initial begin
        bit acc;
        int val;
        int iter;
        reset         = 1'b0;
        m_axis_tready = 1'b0;
        drive(1'b1, 8'h55, 1'b1);
        #1;

        // Reset held with input offered: nothing accepted, outputs cleared.
        repeat (3) step();
        check("rst_data", {24'd0, data_out}, 32'h0);
        check("rst_last", {31'd0, m_axis_tlast}, 32'h0);
        check("rst_valid", {31'd0, m_axis_tvalid}, 32'h0);
        check("rst_ready", {31'd0, s_axis_tready}, 32'h1);

        // First edge after release accepts the offered beat.
        reset = 1'b1;
        step();
        check("first_valid", {31'd0, m_axis_tvalid}, 32'h1);
        check("first_data", {24'd0, data_out}, 32'h55);
        drive(1'b0, 8'hEE, 1'b0);
        m_axis_tready = 1'b1;
        step();
        check("first_drained", {31'd0, m_axis_tvalid}, 32'h0);

        // Streaming at full rate with one clock latency.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            step();
            check("stream_data", {24'd0, data_out}, i);
            check("stream_valid", {31'd0, m_axis_tvalid}, 32'h1);
            check("stream_ready", {31'd0, s_axis_tready}, 32'h1);
        end
        drive(1'b0, 8'h99, 1'b1);
        step();
        check("stream_end", {31'd0, m_axis_tvalid}, 32'h0);

        // Backpressure fills the skid; release drains in order.
        m_axis_tready = 1'b0;
        drive(1'b1, 8'hA5, 1'b0);
        step();
        check("bp_ready1", {31'd0, s_axis_tready}, 32'h1);
        check("bp_data1", {24'd0, data_out}, 32'hA5);
        drive(1'b1, 8'h3C, 1'b1);
        step();
        check("bp_ready2", {31'd0, s_axis_tready}, 32'h0);
        check("bp_hold", {24'd0, data_out}, 32'hA5);
        drive(1'b1, 8'h77, 1'b0);
        step();
        check("bp_full_hold", {24'd0, data_out}, 32'hA5);
        check("bp_full_valid", {31'd0, m_axis_tvalid}, 32'h1);
        drive(1'b0, 8'h00, 1'b0);
        m_axis_tready = 1'b1;
        step();
        check("bp_skid_out", {24'd0, data_out}, 32'h3C);
        check("bp_skid_last", {31'd0, m_axis_tlast}, 32'h1);
        check("bp_ready_back", {31'd0, s_axis_tready}, 32'h1);
        step();
        check("bp_empty", {31'd0, m_axis_tvalid}, 32'h0);

        // tlast stays with its own beat.
        for (int i = 0; i <= 10; i++) begin
            drive(1'b1, 8'(i), i == 10);
            step();
            check("pkt_last", {31'd0, m_axis_tlast}, {31'd0, i == 10});
        end
        drive(1'b0, 8'h00, 1'b0);
        step();

        // Reset mid-transfer discards both held beats immediately.
        m_axis_tready = 1'b0;
        drive(1'b1, 8'hA1, 1'b0);
        step();
        drive(1'b1, 8'hA2, 1'b1);
        step();
        check("fill_full", {31'd0, s_axis_tready}, 32'h0);
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        #1;
        check("async_valid", {31'd0, m_axis_tvalid}, 32'h0);
        check("async_ready", {31'd0, s_axis_tready}, 32'h1);
        check("async_data", {24'd0, data_out}, 32'h0);
        check("async_last", {31'd0, m_axis_tlast}, 32'h0);
        q.delete();
        step();
        reset = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_idle", {31'd0, m_axis_tvalid}, 32'h0);
        end

        // Random backpressure with a continuous 0..255 stream.
        in_count  = 0;
        out_count = 0;
        val  = 0;
        iter = 0;
        while (val < 256 && iter < 5000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                drive(1'b0, 8'($urandom), 1'($urandom));
            else
                drive(1'b1, 8'(val), (val % 7) == 6);
            cycle(acc);
            if (acc) val++;
            iter++;
        end
        check("rand_all_sent", val, 256);
        drive(1'b0, 8'h00, 1'b0);
        m_axis_tready = 1'b1;
        iter = 0;
        while (q.size() > 0 && iter < 10) begin
            step();
            iter++;
        end
        check("rand_drained", q.size(), 0);
        check("rand_out_count", out_count, in_count);
        step();
        check("rand_idle", {31'd0, m_axis_tvalid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
